// File: rtl/l2_tcdm_resp_pkg.sv
// Shared types and constants for the L2/SCM TCDM responder.
// MEM_DW grows to carry one parity bit per byte when TCDM_RESP_PARITY_EN is defined.
package l2_tcdm_resp_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

    localparam logic [31:0] ERR_RDATA = 32'hBADACCE5;
    localparam int PARITY_W = 4;

`ifdef TCDM_RESP_PARITY_EN
    localparam int MEM_DW = 32 + PARITY_W;
`else
    localparam int MEM_DW = 32;
`endif

endpackage

// File: rtl/tcdm_byte_parity.sv
// Even parity per byte: generates parity for a write word and flags any
// byte whose stored parity disagrees with the read word.
module tcdm_byte_parity
    import l2_tcdm_resp_pkg::*;
(
    input  logic [31:0]         wdata,
    output logic [PARITY_W-1:0] wpar,
    input  logic [31:0]         rdata,
    input  logic [PARITY_W-1:0] rpar,
    output logic                mismatch
);

    always_comb begin
        wpar     = '0;
        mismatch = 1'b0;
        for (int i = 0; i < PARITY_W; i++) begin
            wpar[i]  = ^wdata[8*i +: 8];
            mismatch = mismatch | ((^rdata[8*i +: 8]) ^ rpar[i]);
        end
    end

endmodule

// File: rtl/l2_tcdm_responder.sv
// TCDM slave port terminating a single-port SRAM bank with programmable wait states.
// Define TCDM_RESP_PARITY_EN to store and check per-byte even parity in the SRAM.
module l2_tcdm_responder
    import l2_tcdm_resp_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 12,
    parameter logic [31:0] BASE_ADDR   = 32'h1C00_0000,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  tcdm_req_i,
    input  logic [31:0]           tcdm_add_i,
    input  logic                  tcdm_wen_i,
    input  logic [31:0]           tcdm_wdata_i,
    input  logic [3:0]            tcdm_be_i,
    output logic                  tcdm_gnt_o,
    output logic                  tcdm_r_valid_o,
    output logic [31:0]           tcdm_r_rdata_o,
    output logic                  mem_csn_o,
    output logic                  mem_wen_o,
    output logic [3:0]            mem_be_o,
    output logic [ADDR_WIDTH-1:0] mem_add_o,
    output logic [MEM_DW-1:0]     mem_wdata_o,
    input  logic [MEM_DW-1:0]     mem_rdata_i,
    input  logic                  err_clr_i,
    output logic                  err_o
);

    localparam logic [2:0] WAIT_LOAD = (WAIT_CYCLES == 0) ? 3'd0 : 3'(WAIT_CYCLES - 1);

    state_e             state_q, state_d;
    logic [2:0]         cnt_q, cnt_d;
    logic               gnt;
    logic [31:0]        offset;
    logic               in_range;
    logic               access;
    logic               rvalid_q, read_q, oor_q, err_q;
    logic               range_err, par_err;
    logic [MEM_DW-1:0]  wdata_full;

    assign offset   = tcdm_add_i - BASE_ADDR;
    assign in_range = (tcdm_add_i >= BASE_ADDR) && ((offset >> (ADDR_WIDTH + 2)) == 32'd0);
    assign access   = gnt & in_range;
    assign range_err = gnt & ~in_range;

    // A request dropped while waiting is abandoned so the next one pays the full wait.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gnt     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (tcdm_req_i) begin
                    if (WAIT_CYCLES == 0) begin
                        gnt = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = WAIT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (!tcdm_req_i) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    gnt     = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

`ifdef TCDM_RESP_PARITY_EN
    logic [PARITY_W-1:0] wpar;
    logic                par_mismatch;

    tcdm_byte_parity u_parity (
        .wdata    (tcdm_wdata_i),
        .wpar     (wpar),
        .rdata    (mem_rdata_i[31:0]),
        .rpar     (mem_rdata_i[MEM_DW-1:32]),
        .mismatch (par_mismatch)
    );

    assign wdata_full = {wpar, tcdm_wdata_i};
    assign par_err    = read_q & par_mismatch;
`else
    assign wdata_full = tcdm_wdata_i;
    assign par_err    = 1'b0;
`endif

    always_comb begin
        mem_csn_o   = 1'b1;
        mem_wen_o   = 1'b1;
        mem_be_o    = '0;
        mem_add_o   = '0;
        mem_wdata_o = '0;
        if (access) begin
            mem_csn_o   = 1'b0;
            mem_wen_o   = tcdm_wen_i;
            mem_be_o    = tcdm_be_i;
            mem_add_o   = offset[ADDR_WIDTH+1:2];
            mem_wdata_o = wdata_full;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rvalid_q <= 1'b0;
            read_q   <= 1'b0;
            oor_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rvalid_q <= gnt;
            read_q   <= access & tcdm_wen_i;
            oor_q    <= range_err;
            if (range_err || par_err) begin
                err_q <= 1'b1;
            end else if (err_clr_i) begin
                err_q <= 1'b0;
            end
        end
    end

    // Read data comes straight from the SRAM in the response cycle; writes answer with zero.
    always_comb begin
        tcdm_r_rdata_o = '0;
        if (oor_q) begin
            tcdm_r_rdata_o = ERR_RDATA;
        end else if (read_q) begin
            tcdm_r_rdata_o = mem_rdata_i[31:0];
        end
    end

    assign tcdm_gnt_o     = gnt;
    assign tcdm_r_valid_o = rvalid_q;
    assign err_o          = err_q;

endmodule
